fft_frame_adapter: RTL and testbench
====================================

Name: fft_frame_adapter

Overview:
Stream-side driver and consumer for fft_core_top. Collects N complex samples from a valid/ready input stream and presents them as a parallel frame on the core's input buses. Pulses the core start, waits for done, and captures the parallel result. Replays the result as a valid/ready output stream in index order 0..N-1.

Parameters:
N, 16, FFT frame length (power of 2, >=2)
WIDTH, 16, bits per real/imag component (signed two's complement)
TIMEOUT, 1024, max cycles in WAIT before the frame is abandoned (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  adapter accepts input sample
s_real  in  WIDTH  input sample real part
s_imag  in  WIDTH  input sample imag part
core_start  out  1  one-cycle start pulse to FFT core
core_in_real  out  N*WIDTH  frame real parts; element k at [k*WIDTH +: WIDTH]
core_in_imag  out  N*WIDTH  frame imag parts; same packing
core_done  in  1  FFT core done (pulse or level)
core_out_real  in  N*WIDTH  core result real parts; same packing
core_out_imag  in  N*WIDTH  core result imag parts; same packing
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output sample
m_real  out  WIDTH  output sample real part
m_imag  out  WIDTH  output sample imag part
m_index  out  log2(N)  index of current output sample
m_last  out  1  high with index N-1
busy  out  1  high in START, WAIT, DRAIN
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst low, asynchronous) clears all state immediately:
  - state=FILL, counters=0, all buffers=0;
  - core_start=0, m_valid=0, m_real/m_imag/m_index=0, m_last=0, busy=0, err=0.
- s_ready is combinational: high only in FILL.
- FSM states:
  - FILL:
    - On s_valid&&s_ready, write {s_real,s_imag} to input element cnt and increment cnt.
    - The accept with cnt==N-1 moves to START and sets cnt=0.
  - START:
    - core_start=1 for exactly this one cycle.
    - Next state WAIT; wait counter cleared.
  - WAIT:
    - Wait counter increments each cycle.
    - core_done==1 captures core_out_real/imag into the output buffer, sets idx=0, and moves to DRAIN.
    - If the counter reaches TIMEOUT-1 without done: set err=1, drop the frame, return to FILL.
  - DRAIN:
    - m_valid=1; m_real/m_imag = output element idx; m_index=idx; m_last=(idx==N-1).
    - On m_valid&&m_ready, idx increments.
    - The handshake with idx==N-1 returns to FILL and deasserts m_valid.
- Output handshake rules:
  - m_valid, m_real, m_imag, m_index and m_last are registered.
  - While m_valid=1 and m_ready=0, all m_* outputs stay stable.
- Input buffer rules:
  - core_in_real/imag are driven directly from the input buffer registers.
  - The buffer is written only in FILL and is held stable through START and WAIT.
- Latency:
  - Last input accepted at edge t → core_start high in cycle t+1.
  - core_done first sampled high at edge d → m_valid high from cycle d+1 with index 0.
- Ignored events:
  - core_done is ignored outside WAIT. This covers done in FILL or START, and a level-held done left over from the previous frame.
  - Input samples are not accepted outside FILL, since s_ready=0.
- Frame handling: no frame overlap; the next frame's FILL begins the cycle after the last output handshake.
- Data is passed bit-exact, with no scaling, rounding or reordering.
- err is cleared only by reset; the adapter continues operating after a timeout.
- Reset asserted mid-frame in any state discards all data and restarts in FILL.

Test Plan:
1. Reset then idle → s_ready=1, core_start=0, m_valid=0, busy=0, err=0, core_in buses all zero.
2. Stream 16 samples real=k, imag=-k, with s_valid gaps every 3rd cycle → core_in_real element k==k and core_in_imag element k==-k. core_start is high exactly one cycle, the cycle after the 16th accept. s_ready=0 from that cycle on.
3. Core model drives out_real[k]=100+k, out_imag[k]=-200-k and pulses done 5 cycles after start; m_ready toggles 1,0,0,1 → 16 outputs in order with no loss or duplicates, m_last only on index 15, values stable while m_ready=0, s_ready=1 the cycle after the final handshake.
4. Spurious core_done held high during FILL and START → no capture, no DRAIN entry; capture occurs on the first WAIT cycle with done high.
5. TIMEOUT=64, core_done never asserted → err=1 after 64 WAIT cycles, state returns to FILL, no m_valid. A following normal frame completes with err still 1.
6. Assert rst mid-DRAIN at index 7 → m_valid=0, busy=0 immediately (asynchronous). The next full frame processes correctly from index 0.

Source files
------------

// File: rtl/fft_frame_adapter.sv
// Stream-to-frame adapter around fft_core_top: gathers N samples into a parallel frame,
// runs the core once per frame, then replays the parallel result as a stream in index order.
module fft_frame_adapter #(
    parameter int N       = 16,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024,
    localparam int IW     = (N > 1) ? $clog2(N) : 1,
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_real,
    input  logic [WIDTH-1:0]     s_imag,
    output logic                 core_start,
    output logic [N*WIDTH-1:0]   core_in_real,
    output logic [N*WIDTH-1:0]   core_in_imag,
    input  logic                 core_done,
    input  logic [N*WIDTH-1:0]   core_out_real,
    input  logic [N*WIDTH-1:0]   core_out_imag,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_real,
    output logic [WIDTH-1:0]     m_imag,
    output logic [IW-1:0]        m_index,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           state_dbg
);

    // Both streams use the same handshake: a transfer happens on a rising edge where
    // valid and ready are both high; once valid is raised, the payload and valid hold
    // unchanged until that transfer, and ready may toggle freely without side effects.

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        cnt;
    logic [TW-1:0]        wcnt;
    logic [N*WIDTH-1:0]   in_real;
    logic [N*WIDTH-1:0]   in_imag;
    logic [N*WIDTH-1:0]   out_real;
    logic [N*WIDTH-1:0]   out_imag;
    logic [IW-1:0]        idx_nxt;
    logic                 last_in;
    logic                 timeout_hit;

    assign last_in      = (cnt == IW'(N - 1));
    assign timeout_hit  = (wcnt == TW'(TIMEOUT - 1));
    assign idx_nxt      = m_index + IW'(1);
    assign core_in_real = in_real;
    assign core_in_imag = in_imag;
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && last_in) begin
                    state_nxt = START;
                end
            end
            START: begin
                core_start = 1'b1;
                busy       = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // A done arriving on the final allowed cycle still wins over the timeout.
                if (core_done) begin
                    state_nxt = DRAIN;
                end else if (timeout_hit) begin
                    state_nxt = FILL;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (m_ready && m_last) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            wcnt     <= '0;
            in_real  <= '0;
            in_imag  <= '0;
            out_real <= '0;
            out_imag <= '0;
            m_valid  <= 1'b0;
            m_real   <= '0;
            m_imag   <= '0;
            m_index  <= '0;
            m_last   <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (s_valid) begin
                        in_real[int'(cnt)*WIDTH +: WIDTH] <= s_real;
                        in_imag[int'(cnt)*WIDTH +: WIDTH] <= s_imag;
                        cnt <= last_in ? '0 : cnt + IW'(1);
                    end
                end
                START: begin
                    wcnt <= '0;
                end
                WAIT: begin
                    wcnt <= wcnt + TW'(1);
                    if (core_done) begin
                        out_real <= core_out_real;
                        out_imag <= core_out_imag;
                        m_valid  <= 1'b1;
                        m_real   <= core_out_real[WIDTH-1:0];
                        m_imag   <= core_out_imag[WIDTH-1:0];
                        m_index  <= '0;
                        m_last   <= (N == 1);
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_index <= '0;
                        end else begin
                            m_real  <= out_real[int'(idx_nxt)*WIDTH +: WIDTH];
                            m_imag  <= out_imag[int'(idx_nxt)*WIDTH +: WIDTH];
                            m_index <= idx_nxt;
                            m_last  <= (idx_nxt == IW'(N - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_adapter.sv
// Bench for fft_frame_adapter: a frame-scenario table plus hand-written corner sequences,
// with a behavioural FFT-core stand-in and an expected-output queue.
module tb_fft_frame_adapter;

    localparam int N       = 16;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int IW      = $clog2(N);
    localparam int BW      = N * WIDTH;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [WIDTH-1:0]  s_real;
    logic [WIDTH-1:0]  s_imag;
    logic              core_start;
    logic [BW-1:0]     core_in_real;
    logic [BW-1:0]     core_in_imag;
    logic              core_done;
    logic [BW-1:0]     core_out_real;
    logic [BW-1:0]     core_out_imag;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_real;
    logic [WIDTH-1:0]  m_imag;
    logic [IW-1:0]     m_index;
    logic              m_last;
    logic              busy;
    logic              err;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [2*WIDTH-1:0] exp_q[$];
    logic [BW-1:0]      exp_in_real;
    logic [BW-1:0]      exp_in_imag;

    int done_delay   = 5;
    bit core_respond = 1'b1;
    int out_mode     = 0;

    typedef struct {
        int gap_mode;     // 0 always valid, 1 gap every 3rd cycle, 2 random
        int data_mode;    // 0 ramp real=k imag=-k, 1 random
        int ready_mode;   // 0 pattern 1,0,0,1, 1 random, 2 always ready
        int done_delay;
        bit respond;
        int out_mode;     // 0 real=100+k imag=-200-k, 1 random
        bit exp_err;
        int exp_outputs;
    } frame_vec_t;

    frame_vec_t vecs[6];

    fft_frame_adapter #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_real        (s_real),
        .s_imag        (s_imag),
        .core_start    (core_start),
        .core_in_real  (core_in_real),
        .core_in_imag  (core_in_imag),
        .core_done     (core_done),
        .core_out_real (core_out_real),
        .core_out_imag (core_out_imag),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_real        (m_real),
        .m_imag        (m_imag),
        .m_index       (m_index),
        .m_last        (m_last),
        .busy          (busy),
        .err           (err),
        .state_dbg     (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents a fresh result frame on the core outputs and queues it as expected stream output.
    task automatic load_core_out(input int mode);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] i;
        for (int k = 0; k < N; k++) begin
            if (mode == 0) begin
                r = WIDTH'(100 + k);
                i = WIDTH'(-200 - k);
            end else begin
                r = WIDTH'($urandom);
                i = WIDTH'($urandom);
            end
            core_out_real[k*WIDTH +: WIDTH] = r;
            core_out_imag[k*WIDTH +: WIDTH] = i;
            exp_q.push_back({r, i});
        end
    endtask

    task automatic feed_frame(input int gap_mode, input int data_mode);
        int k     = 0;
        int cyc   = 0;
        int early = 0;
        bit v;
        bit acc;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] i;
        while (k < N && cyc < 400) begin
            case (gap_mode)
                1:       v = ((cyc % 3) != 2);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            if (data_mode == 0) begin
                r = WIDTH'(k);
                i = WIDTH'(-k);
            end else begin
                r = WIDTH'($urandom);
                i = WIDTH'($urandom);
            end
            s_valid = v;
            s_real  = r;
            s_imag  = i;
            if (core_start) early++;
            acc = v && s_ready;
            if (acc) begin
                exp_in_real[k*WIDTH +: WIDTH] = r;
                exp_in_imag[k*WIDTH +: WIDTH] = i;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) k++;
        end
        s_valid = 1'b0;
        if (k < N) check("feed_timeout", k, N);
        check("no_early_start", early, 0);
        check("start_after_last", core_start, 1);
        check("s_ready_low_in_start", s_ready, 0);
    endtask

    task automatic drain(input int ready_mode, input int stop_at, output int got);
        int cyc = 0;
        bit hs;
        got = 0;
        while (got < stop_at && cyc < 400) begin
            case (ready_mode)
                0:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                1:       m_ready = $urandom_range(0, 1) != 0;
                default: m_ready = 1'b1;
            endcase
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("m_data", {m_real, m_imag}, exp_q[0]);
                end
                check("m_index", m_index, got[IW-1:0]);
                check("m_last", m_last, (got == N - 1));
            end
            hs = m_valid && m_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got++;
            end
        end
        m_ready = 1'b0;
        if (got < stop_at) check("drain_timeout", got, stop_at);
        if (stop_at == N) begin
            check("m_valid_low_after_last", m_valid, 0);
            check("s_ready_after_last", s_ready, 1);
        end
    endtask

    task automatic run_frame(input frame_vec_t v);
        int got = 0;
        int vc  = 0;
        done_delay   = v.done_delay;
        core_respond = v.respond;
        out_mode     = v.out_mode;
        feed_frame(v.gap_mode, v.data_mode);
        if (v.respond) begin
            drain(v.ready_mode, N, got);
        end else begin
            repeat (TIMEOUT) begin
                @(posedge clk); #1;
                if (m_valid) vc++;
            end
            check("busy_last_wait_cycle", busy, 1);
            check("s_ready_last_wait_cycle", s_ready, 0);
            @(posedge clk); #1;
            if (m_valid) vc++;
            check("timeout_back_to_fill", s_ready, 1);
            check("timeout_not_busy", busy, 0);
            check("timeout_err", err, 1);
            check("timeout_no_valid", vc, 0);
        end
        check("frame_outputs", got, v.exp_outputs);
        check("err_after_frame", err, v.exp_err);
    endtask

    // behavioural FFT-core stand-in
    initial begin
        core_done     = 1'b0;
        core_out_real = '0;
        core_out_imag = '0;
        forever begin
            @(posedge clk); #1;
            if (core_start && rst) begin
                check("core_in_real", core_in_real, exp_in_real);
                check("core_in_imag", core_in_imag, exp_in_imag);
                if (core_respond) begin
                    for (int d = 1; d <= done_delay; d++) begin
                        @(posedge clk); #1;
                        if (d == 1) check("start_one_cycle", core_start, 0);
                    end
                    load_core_out(out_mode);
                    check("core_in_held_real", core_in_real, exp_in_real);
                    check("core_in_held_imag", core_in_imag, exp_in_imag);
                    core_done = 1'b1;
                    @(posedge clk); #1;
                    core_done = 1'b0;
                    check("first_out_valid", m_valid, 1);
                    check("first_out_index", m_index, 0);
                end
            end
        end
    end

    initial begin
        int got;
        frame_vec_t post;

        vecs[0] = '{1, 0, 0, 5,  1'b1, 0, 1'b0, N};
        vecs[1] = '{0, 1, 1, 1,  1'b1, 1, 1'b0, N};
        vecs[2] = '{2, 1, 2, 9,  1'b1, 1, 1'b0, N};
        vecs[3] = '{2, 1, 2, 5,  1'b0, 1, 1'b1, 0};
        vecs[4] = '{1, 1, 1, 3,  1'b1, 1, 1'b1, N};
        vecs[5] = '{2, 1, 1, 12, 1'b1, 1, 1'b1, N};

        rst     = 1'b0;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        m_ready = 1'b0;
        exp_in_real = '0;
        exp_in_imag = '0;

        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_s_ready", s_ready, 1);
        check("idle_core_start", core_start, 0);
        check("idle_m_valid", m_valid, 0);
        check("idle_busy", busy, 0);
        check("idle_err", err, 0);
        check("idle_m_index", m_index, 0);
        check("idle_m_last", m_last, 0);
        check("idle_core_in_real", core_in_real, 0);
        check("idle_core_in_imag", core_in_imag, 0);

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v]);
        end

        // core_done held high through FILL and START is only honoured once in WAIT
        core_respond = 1'b0;
        load_core_out(1);
        core_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("done_ignored_fill_valid", m_valid, 0);
        check("done_ignored_fill_busy", busy, 0);
        feed_frame(0, 1);
        check("done_ignored_fill_no_drain", m_valid, 0);
        @(posedge clk); #1;
        check("done_ignored_start", m_valid, 0);
        check("busy_in_wait", busy, 1);
        @(posedge clk); #1;
        check("capture_first_wait", m_valid, 1);
        check("capture_first_index", m_index, 0);
        core_done = 1'b0;
        drain(1, N, got);
        check("held_done_outputs", got, N);

        // reset in the middle of DRAIN
        core_respond = 1'b1;
        done_delay   = 4;
        out_mode     = 1;
        feed_frame(1, 1);
        drain(2, 7, got);
        check("pre_reset_index", m_index, 7);
        rst = 1'b0;
        #1;
        check("reset_m_valid", m_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_s_ready", s_ready, 1);
        check("reset_core_in_real", core_in_real, 0);
        check("reset_m_index", m_index, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        post = '{2, 1, 1, 7, 1'b1, 1, 1'b0, N};
        run_frame(post);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
